// File: rtl/fir_fixed_pkg.sv
// Shared types for the FIR-intermediate to fixed-point converter: input record,
// value classes and rounding modes.
package fir_fixed_pkg;

  localparam int FIR_TE_W   = 8;
  localparam int FIR_FRAC_W = 8;

  typedef struct packed {
    logic                  sign;
    logic [FIR_TE_W-1:0]   te;
    logic [FIR_FRAC_W-1:0] frac;
  } fir_t;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    TINY   = 2'd1,
    NORMAL = 2'd2,
    BIG    = 2'd3
  } fx_class_e;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  // Ties go to the even neighbour; truncation never increments.
  function automatic logic rne_round_up(input logic lsb, input logic guard,
                                        input logic sticky, input logic mode);
    return mode & guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/fir_to_fixed_stream_round_sat.sv
// Combinational rounding, negation and saturation of an unsigned magnitude
// into an FX_B-bit two's-complement word.
module fx_round_sat
  import fir_fixed_pkg::*;
#(
  parameter int MAG_W = 26,
  parameter int FX_B  = 16
) (
  input  logic [MAG_W-1:0] mag_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  input  logic             sign_i,
  input  logic             big_i,
  input  logic             rne_i,
  output logic [FX_B-1:0]  result_o,
  output logic             overflow_o,
  output logic             inexact_o
);

  localparam logic [MAG_W-1:0] MIN_MAG = MAG_W'(1) << (FX_B - 1);
  localparam logic [FX_B-1:0]  POS_SAT = {1'b0, {(FX_B-1){1'b1}}};
  localparam logic [FX_B-1:0]  NEG_SAT = {1'b1, {(FX_B-1){1'b0}}};

  logic             round_up_s;
  logic [MAG_W-1:0] rounded_s;
  logic [FX_B-1:0]  mag_fx_s;

  // A magnitude of exactly 2^(FX_B-1) is legal only as the unrounded most-negative value.
  always_comb begin
    round_up_s = rne_round_up(mag_i[0], guard_i, sticky_i, rne_i);
    rounded_s  = mag_i + {{(MAG_W-1){1'b0}}, round_up_s};
    mag_fx_s   = rounded_s[FX_B-1:0];
    overflow_o = big_i | (round_up_s & (rounded_s >= MIN_MAG));
    if (overflow_o) begin
      result_o  = sign_i ? NEG_SAT : POS_SAT;
      inexact_o = 1'b0;
    end else begin
      result_o  = sign_i ? (~mag_fx_s + FX_B'(1)) : mag_fx_s;
      inexact_o = guard_i | sticky_i;
    end
  end

endmodule

// File: rtl/fir_to_fixed_stream.sv
// Two-stage streaming converter from FIR posit intermediate form to a
// saturating, rounded Fx<FX_M,FX_B> word with valid/ready handshake.
module fir_to_fixed_stream
  import fir_fixed_pkg::*;
#(
  parameter int FIR_TE_SIZE   = 8,
  parameter int FIR_FRAC_SIZE = 8,
  parameter int FX_M          = 8,
  parameter int FX_B          = 16,
  parameter bit ROUND_RNE     = 1'b1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [FIR_TE_SIZE+FIR_FRAC_SIZE:0]   fir_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  output logic [FX_B-1:0]                      fixed_o,
  output logic                                 overflow_o,
  output logic                                 inexact_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  input  logic                                 clear_i,
  output logic                                 ovf_sticky_o
);

  localparam int FRAC_BITS = FX_B - FX_M;
  localparam int SH_W      = FIR_FRAC_SIZE + FX_B + 2;
  localparam int S_W       = $clog2(SH_W) + 2;
  localparam int TE_MAX    = FX_M - 1;
  localparam int TE_TINY   = -FRAC_BITS - 2;
  localparam int S_OFS     = FRAC_BITS - (FIR_FRAC_SIZE - 1);
  localparam logic [FIR_FRAC_SIZE-1:0] MANT_ONE = {1'b1, {(FIR_FRAC_SIZE-1){1'b0}}};

  if (FX_M < 2)          begin : g_err_fx_m    $error("FX_M must be at least 2");          end
  if (FX_M >= FX_B)      begin : g_err_fx_b    $error("FX_M must be less than FX_B");      end
  if (FIR_FRAC_SIZE < 2) begin : g_err_frac    $error("FIR_FRAC_SIZE must be at least 2"); end
  if (FIR_TE_SIZE < 2)   begin : g_err_te      $error("FIR_TE_SIZE must be at least 2");   end

  logic                     in_sign_s;
  logic [FIR_TE_SIZE-1:0]   in_te_s;
  logic [FIR_FRAC_SIZE-1:0] in_frac_s;
  logic signed [31:0]       te_int_s;
  logic                     exact_neg_s;
  logic                     en1_s, en2_s;

  logic                     v1_q, v1_d, v2_q, v2_d;
  logic                     sign1_q, sign1_d;
  logic [FIR_FRAC_SIZE-1:0] frac1_q, frac1_d;
  fx_class_e                cls1_q, cls1_d;
  logic [S_W-1:0]           shift1_q, shift1_d;

  logic [SH_W-1:0]          frac_w_s, mag_s;
  logic [S_W-1:0]           rsh_s;
  logic                     guard_s, sticky_s;
  logic [FX_B-1:0]          res_s;
  logic                     res_ovf_s, res_inx_s;

  logic [FX_B-1:0]          fixed_q, fixed_d;
  logic                     ovf_q, ovf_d, inx_q, inx_d;
  logic                     sticky_q, sticky_d;

  assign {in_sign_s, in_te_s, in_frac_s} = fir_i;
  assign te_int_s = {{(32-FIR_TE_SIZE){in_te_s[FIR_TE_SIZE-1]}}, in_te_s};

  assign en2_s      = !v2_q | out_ready_i;
  assign en1_s      = !v1_q | en2_s;
  assign in_ready_o = en1_s;

  // Stage 1: classify and precompute the alignment shift.
  always_comb begin
    exact_neg_s = in_sign_s & (te_int_s == TE_MAX) & (in_frac_s == MANT_ONE);
    v1_d        = en1_s ? in_valid_i : v1_q;
    sign1_d     = sign1_q;
    frac1_d     = frac1_q;
    cls1_d      = cls1_q;
    shift1_d    = shift1_q;
    if (en1_s & in_valid_i) begin
      sign1_d  = in_sign_s;
      frac1_d  = in_frac_s;
      shift1_d = te_int_s[S_W-1:0] + S_W'(S_OFS);
      if (in_frac_s == '0) begin
        cls1_d = ZERO;
      end else if ((te_int_s > TE_MAX) || ((te_int_s == TE_MAX) && !exact_neg_s)) begin
        cls1_d = BIG;
      end else if (te_int_s < TE_TINY) begin
        cls1_d = TINY;
      end else begin
        cls1_d = NORMAL;
      end
    end
  end

  // Stage 2: align the mantissa, keeping guard and sticky on right shifts.
  always_comb begin
    frac_w_s = {{(SH_W-FIR_FRAC_SIZE){1'b0}}, frac1_q};
    rsh_s    = ~shift1_q + S_W'(1);
    if (!shift1_q[S_W-1]) begin
      mag_s    = frac_w_s << shift1_q;
      guard_s  = 1'b0;
      sticky_s = 1'b0;
    end else begin
      mag_s    = frac_w_s >> rsh_s;
      guard_s  = |(frac_w_s & (SH_W'(1) << (rsh_s - S_W'(1))));
      sticky_s = |(frac_w_s & ((SH_W'(1) << (rsh_s - S_W'(1))) - SH_W'(1)));
    end
    case (cls1_q)
      ZERO: begin
        mag_s = '0; guard_s = 1'b0; sticky_s = 1'b0;
      end
      TINY: begin
        mag_s = '0; guard_s = 1'b0; sticky_s = 1'b1;
      end
      NORMAL, BIG: begin
        mag_s = mag_s;
      end
      default: begin
        mag_s = '0; guard_s = 1'b0; sticky_s = 1'b0;
      end
    endcase
  end

  fx_round_sat #(
    .MAG_W (SH_W),
    .FX_B  (FX_B)
  ) u_round_sat (
    .mag_i      (mag_s),
    .guard_i    (guard_s),
    .sticky_i   (sticky_s),
    .sign_i     (sign1_q),
    .big_i      (cls1_q == BIG),
    .rne_i      (ROUND_RNE),
    .result_o   (res_s),
    .overflow_o (res_ovf_s),
    .inexact_o  (res_inx_s)
  );

  // Output register and sticky overflow; a coincident overflow transfer beats clear.
  always_comb begin
    v2_d    = en2_s ? v1_q : v2_q;
    fixed_d = fixed_q;
    ovf_d   = ovf_q;
    inx_d   = inx_q;
    if (en2_s & v1_q) begin
      fixed_d = res_s;
      ovf_d   = res_ovf_s;
      inx_d   = res_inx_s;
    end
    if (v2_q & out_ready_i & ovf_q) begin
      sticky_d = 1'b1;
    end else if (clear_i) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Pipeline state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      sign1_q  <= 1'b0;
      frac1_q  <= '0;
      cls1_q   <= ZERO;
      shift1_q <= '0;
      fixed_q  <= '0;
      ovf_q    <= 1'b0;
      inx_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      sign1_q  <= sign1_d;
      frac1_q  <= frac1_d;
      cls1_q   <= cls1_d;
      shift1_q <= shift1_d;
      fixed_q  <= fixed_d;
      ovf_q    <= ovf_d;
      inx_q    <= inx_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid_o  = v2_q;
  assign fixed_o      = fixed_q;
  assign overflow_o   = ovf_q;
  assign inexact_o    = inx_q;
  assign ovf_sticky_o = sticky_q;

endmodule

// File: tb/tb_fir_to_fixed_stream.sv
// Directed and streamed checks of fir_to_fixed_stream at default parameters,
// with a truncating instance alongside for the round-toward-zero case.
module tb_fir_to_fixed_stream;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, clear;
  logic [16:0] fir;
  logic        in_ready, out_valid, ovf, inx, sticky;
  logic [15:0] fixed;
  logic        t_in_ready, t_out_valid, t_ovf, t_inx, t_sticky;
  logic [15:0] t_fixed;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fir_to_fixed_stream u_dut (
    .clk_i(clk), .rst_i(rst), .fir_i(fir), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fixed_o(fixed), .overflow_o(ovf), .inexact_o(inx), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .clear_i(clear), .ovf_sticky_o(sticky)
  );

  fir_to_fixed_stream #(.ROUND_RNE(1'b0)) u_trunc (
    .clk_i(clk), .rst_i(rst), .fir_i(fir), .in_valid_i(in_valid), .in_ready_o(t_in_ready),
    .fixed_o(t_fixed), .overflow_o(t_ovf), .inexact_o(t_inx), .out_valid_o(t_out_valid),
    .out_ready_i(out_ready), .clear_i(clear), .ovf_sticky_o(t_sticky)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one item, then wait (bounded) until its result is on the output.
  task automatic send(input string tag, input logic s, input logic [7:0] te, input logic [7:0] fr);
    @(negedge clk);
    fir = {s, te, fr}; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8 && !out_valid; i++) @(negedge clk);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] fx, input logic o, input logic x);
    check({tag, "_fixed"}, {16'd0, fixed}, {16'd0, fx});
    check({tag, "_flags"}, {30'd0, ovf, inx}, {30'd0, o, x});
  endtask

  function automatic logic [17:0] model(input logic s, input int t, input logic [7:0] fr);
    longint x, ip, rem, r;
    bit up, o, ix;
    logic [15:0] fx;
    x   = longint'(fr) << (t + 21);
    ip  = x >> 20;
    rem = x & 64'hFFFFF;
    up  = (rem > 64'h80000) || ((rem == 64'h80000) && ip[0]);
    r   = ip + (up ? 64'd1 : 64'd0);
    o   = s ? (r > 64'd32768) : (r > 64'd32767);
    ix  = !o && (rem != 64'd0);
    if (o) begin
      fx = s ? 16'h8000 : 16'h7FFF;
    end else begin
      r  = s ? -r : r;
      fx = r[15:0];
    end
    return {o, ix, fx};
  endfunction

  initial begin
    logic [17:0] q[$];
    logic [17:0] held, exp_v;
    logic        cur_s;
    int          cur_t, sent, got;
    logic [7:0]  cur_f;
    bit          stalled, accepted, seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0; fir = 17'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_fixed", {16'd0, fixed}, 32'd0);
    check("rst_flags", {29'd0, ovf, inx, sticky}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    send("one", 1'b0, 8'h00, 8'h80);        expect_out("one", 16'h0100, 1'b0, 1'b0);
    send("six", 1'b0, 8'h02, 8'hC0);        expect_out("six", 16'h0600, 1'b0, 1'b0);
    send("neg_half", 1'b1, 8'hFF, 8'h80);   expect_out("neg_half", 16'hFF80, 1'b0, 1'b0);
    send("neg_zero", 1'b1, 8'h05, 8'h00);   expect_out("neg_zero", 16'h0000, 1'b0, 1'b0);
    send("pos_sat", 1'b0, 8'h07, 8'h80);    expect_out("pos_sat", 16'h7FFF, 1'b1, 1'b0);
    send("min_neg", 1'b1, 8'h07, 8'h80);    expect_out("min_neg", 16'h8000, 1'b0, 1'b0);
    send("rne_tie", 1'b0, 8'hF8, 8'hC0);    expect_out("rne_tie", 16'h0002, 1'b0, 1'b1);
    check("trunc_fixed", {16'd0, t_fixed}, 32'h0001);
    check("trunc_flags", {30'd0, t_ovf, t_inx}, 32'd1);
    send("rne_neg", 1'b1, 8'hF8, 8'hC0);    expect_out("rne_neg", 16'hFFFE, 1'b0, 1'b1);
    check("trunc_neg", {16'd0, t_fixed}, 32'h0000FFFF);
    send("tiny", 1'b0, 8'hE2, 8'h80);       expect_out("tiny", 16'h0000, 1'b0, 1'b1);

    // Sticky: set by the te=7 overflow earlier, then cleared, set again, set-wins.
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("sticky_clr", {31'd0, sticky}, 32'd0);
    send("big20", 1'b0, 8'h14, 8'h80);      expect_out("big20", 16'h7FFF, 1'b1, 1'b0);
    @(negedge clk);
    check("sticky_set", {31'd0, sticky}, 32'd1);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("sticky_clr2", {31'd0, sticky}, 32'd0);
    send("big_neg", 1'b1, 8'h14, 8'h80);    expect_out("big_neg", 16'h8000, 1'b1, 1'b0);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("sticky_wins", {31'd0, sticky}, 32'd1);

    // Random stream with random backpressure against the reference model.
    sent = 0; got = 0; stalled = 1'b0; accepted = 1'b1; held = 18'd0;
    cur_s = 1'b0; cur_t = 0; cur_f = 8'd0;
    for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
      @(negedge clk);
      if (accepted) begin
        if (sent < 100) begin
          cur_s = 1'($urandom_range(1));
          cur_t = int'($urandom_range(23)) - 14;
          cur_f = ($urandom_range(9) == 0) ? 8'h00 : (8'h80 | 8'($urandom_range(127)));
          fir = {cur_s, 8'(cur_t), cur_f};
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      accepted = 1'b0;
      out_ready = 1'($urandom_range(1));
      #1;
      if (stalled) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {14'd0, ovf, inx, fixed}, {14'd0, held});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious", 32'd1, 32'd0);
        end else begin
          exp_v = q.pop_front();
          check("stream", {14'd0, ovf, inx, fixed}, {14'd0, exp_v});
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held    = {ovf, inx, fixed};
      if (in_valid && in_ready) begin
        q.push_back(model(cur_s, cur_t, cur_f));
        sent++;
        accepted = 1'b1;
      end
    end
    check("stream_count", got, 32'd100);
    in_valid = 1'b0;

    // Two items stalled in the pipe, then reset discards them.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; fir = {1'b0, 8'h00, 8'h80};
    @(negedge clk);
    fir = {1'b0, 8'h02, 8'hC0};
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("full_ready", {31'd0, in_ready}, 32'd0);
    check("full_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("no_stale", {31'd0, seen}, 32'd0);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
